// File: rtl/gate_response_checker.sv
// gate_response_checker: clocked stimulus/response end for a combinational
// gate under test. It applies every input vector in ascending order, holds
// each one for SETTLE cycles, samples the gate output and compares it with
// the TRUTH table. It reports a saturating error count, the first failing
// vector, and a pass flag once the sweep is done.
//
// Control handshake: a one-cycle start pulse is accepted only in IDLE or
// DONE (that is, only when busy=0 and the FSM is not on the edge that
// enters DONE). busy stays high for the whole sweep. done rises on the
// cycle after the last vector is sampled and stays high until the next
// accepted start or reset. pass, err_count and first_fail_* are only
// meaningful while done=1.

module gate_response_checker #(
    parameter int                       N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]     TRUTH  = 4'b0111,
    parameter int                       SETTLE = 2,
    parameter int                       ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  vec_out,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    // Sized so that it can hold SETTLE itself without overflowing.
    localparam int CNT_W = $clog2(SETTLE) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST    = '1;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             mismatch;

    // Case inequality makes X or Z on the gate output count as a failure.
    // This value is consumed only in the SAMPLE state, so it is never
    // visible on an output without first passing through a register.
    assign mismatch = (dut_out !== TRUTH[vec_out]);

    // Sweep sequencer. All outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            settle_cnt       <= '0;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state            <= S_SETTLE;
                        settle_cnt       <= '0;
                        vec_out          <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end

                S_SETTLE: begin
                    // vec_out is held here; only the counter moves.
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec_out;
                        end
                    end
                    if (vec_out == VEC_LAST) begin
                        // The final sample is included directly, because
                        // err_count has not absorbed it yet.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        vec_out    <= vec_out + 1'b1;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker. Two instances are used: one with the
// default parameters (2-input NAND), and one with N_IN=3, TRUTH=0,
// SETTLE=1, ERR_W=2. The gate outputs are modelled in the bench. A
// reference model that works directly from the gate values and the truth
// table predicts every sweep result into a queue. Monitors pop from the
// queue and compare whenever done rises.

module tb_gate_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;

    // Instance A: defaults
    logic [1:0] vec_a;
    wire        dut_out_a;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic [7:0] err_a;
    logic [1:0] ffvec_a;

    // Instance B: 3 inputs, all-zero truth table, SETTLE=1, 2-bit counter
    logic [2:0] vec_b;
    logic       dut_out_b;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [1:0] err_b;
    logic [2:0] ffvec_b;

    // Gate models: 0 NAND, 1 stuck-at-1, 2 AND, 3 floating, 4 random table
    int         mode_a = 0;
    logic [3:0] table_a = '0;
    logic       gate_a;
    int         mode_b = 0;
    logic [7:0] table_b = '0;

    always_comb begin
        case (mode_a)
            0:       gate_a = ~(vec_a[1] & vec_a[0]);
            1:       gate_a = 1'b1;
            2:       gate_a = vec_a[1] & vec_a[0];
            default: gate_a = table_a[vec_a];
        endcase
    end
    assign dut_out_a = (mode_a == 3) ? 1'bz : gate_a;

    always_comb begin
        case (mode_b)
            0:       dut_out_b = 1'b0;
            1:       dut_out_b = 1'b1;
            default: dut_out_b = table_b[vec_b];
        endcase
    end

    gate_response_checker u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_a),
        .vec_out          (vec_a),
        .dut_out          (dut_out_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .err_count        (err_a),
        .first_fail_valid (ffv_a),
        .first_fail_vec   (ffvec_a)
    );

    gate_response_checker #(
        .N_IN   (3),
        .TRUTH  (8'h00),
        .SETTLE (1),
        .ERR_W  (2)
    ) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .vec_out          (vec_b),
        .dut_out          (dut_out_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_b),
        .first_fail_valid (ffv_b),
        .first_fail_vec   (ffvec_b)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  err;
        logic        ffv;
        logic [2:0]  ffvec;
        logic        pass;
        logic [15:0] lat;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model. Every vector is applied once. The vector counts as a
    // failure if the gate value differs from the table (X and Z count as
    // failures). The count saturates at err_max. Each vector takes settle
    // cycles plus one sample cycle.
    function automatic exp_t model(input int n_in, input logic [7:0] truth,
                                   input int settle, input int err_max,
                                   input logic [7:0] gv);
        exp_t e;
        e = '0;
        for (int v = 0; v < (1 << n_in); v++) begin
            if (gv[v] !== truth[v]) begin
                if (!e.ffv) begin
                    e.ffv   = 1'b1;
                    e.ffvec = 3'(v);
                end
                if (int'(e.err) < err_max) e.err = e.err + 8'd1;
            end
        end
        e.pass = (e.err == 8'd0);
        e.lat  = 16'((1 << n_in) * (settle + 1));
        return e;
    endfunction

    // ---------------- monitors ----------------
    int   busy_cyc_a = 0;
    logic done_prev_a = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cyc_a  = 0;
            done_prev_a = 1'b0;
        end else begin
            if (busy_a) busy_cyc_a++;
            if (done_a && !done_prev_a) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_err_count", 32'(err_a), 32'(e.err));
                    chk("a_first_fail_valid", 32'(ffv_a), 32'(e.ffv));
                    chk("a_first_fail_vec", 32'(ffvec_a), 32'(e.ffvec[1:0]));
                    chk("a_pass", 32'(pass_a), 32'(e.pass));
                    chk("a_busy_cycles", 32'(busy_cyc_a), 32'(e.lat));
                    chk("a_vec_at_done", 32'(vec_a), 32'd3);
                    chk("a_busy_low_at_done", 32'(busy_a), 32'd0);
                end
                busy_cyc_a = 0;
            end
            done_prev_a = done_a;
        end
    end

    int   busy_cyc_b = 0;
    logic done_prev_b = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cyc_b  = 0;
            done_prev_b = 1'b0;
        end else begin
            if (busy_b) busy_cyc_b++;
            if (done_b && !done_prev_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_err_count", 32'(err_b), 32'(e.err));
                    chk("b_first_fail_valid", 32'(ffv_b), 32'(e.ffv));
                    chk("b_first_fail_vec", 32'(ffvec_b), 32'(e.ffvec));
                    chk("b_pass", 32'(pass_b), 32'(e.pass));
                    chk("b_busy_cycles", 32'(busy_cyc_b), 32'(e.lat));
                    chk("b_vec_at_done", 32'(vec_b), 32'd7);
                end
                busy_cyc_b = 0;
            end
            done_prev_b = done_b;
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_done_a();
        int i;
        for (i = 0; i < 200 && !done_a; i++) @(negedge clk);
        if (!done_a) chk("a_done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic sweep_a(input int mode, input logic [3:0] tbl,
                           input bit mid_start, input bit end_start);
        logic [7:0] gv;
        @(negedge clk);
        mode_a  = mode;
        table_a = tbl;
        #1;
        gv = '0;
        for (int v = 0; v < 4; v++) begin
            case (mode)
                0:       gv[v] = ~(v[1] & v[0]);
                1:       gv[v] = 1'b1;
                2:       gv[v] = v[1] & v[0];
                3:       gv[v] = dut_out_a;
                default: gv[v] = tbl[v];
            endcase
        end
        exp_a.push_back(model(2, 8'h07, 2, 255, gv));
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        if (mid_start) begin
            repeat (4) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
        end
        if (end_start) begin
            // Start is high on exactly the edge that enters DONE.
            repeat (11) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
            @(negedge clk);
            chk("a_start_at_done_edge_done", 32'(done_a), 32'd1);
            chk("a_start_at_done_edge_busy", 32'(busy_a), 32'd0);
        end
        wait_done_a();
    endtask

    task automatic sweep_b(input int mode, input logic [7:0] tbl);
        logic [7:0] gv;
        int i;
        @(negedge clk);
        mode_b  = mode;
        table_b = tbl;
        for (int v = 0; v < 8; v++) begin
            case (mode)
                0:       gv[v] = 1'b0;
                1:       gv[v] = 1'b1;
                default: gv[v] = tbl[v];
            endcase
        end
        exp_b.push_back(model(3, 8'h00, 1, 3, gv));
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (i = 0; i < 200 && !done_b; i++) @(negedge clk);
        if (!done_b) chk("b_done_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        #2;
        chk("rst_a_vec", 32'(vec_a), 32'd0);
        chk("rst_a_flags", {28'd0, busy_a, done_a, pass_a, ffv_a}, 32'd0);
        chk("rst_a_err", 32'(err_a), 32'd0);
        chk("rst_a_ffvec", 32'(ffvec_a), 32'd0);
        chk("rst_b_vec", 32'(vec_b), 32'd0);
        chk("rst_b_flags", {28'd0, busy_b, done_b, pass_b, ffv_b}, 32'd0);
        chk("rst_b_err", 32'(err_b), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep_a(0, 4'h0, 1'b0, 1'b1);   // ideal NAND, start on DONE edge
        sweep_a(1, 4'h0, 1'b0, 1'b0);   // stuck-at-1
        sweep_a(2, 4'h0, 1'b0, 1'b0);   // AND instead of NAND
        sweep_a(0, 4'h0, 1'b0, 1'b0);   // NAND reconnected
        sweep_a(3, 4'h0, 1'b1, 1'b0);   // floating, restart mid-sweep
        for (int k = 0; k < 6; k++) sweep_a(4, 4'($urandom_range(0, 15)), 1'b0, 1'b0);

        sweep_b(1, 8'h00);              // all fail, count saturates
        sweep_b(0, 8'h00);              // all match
        for (int k = 0; k < 4; k++) sweep_b(4, 8'($urandom_range(0, 255)));

        // Reset in the middle of a sweep: outputs clear without a clock edge.
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_vec", 32'(vec_a), 32'd0);
        chk("midrst_a_flags", {28'd0, busy_a, done_a, pass_a, ffv_a}, 32'd0);
        chk("midrst_a_err", 32'(err_a), 32'd0);
        chk("midrst_b_flags", {28'd0, busy_b, done_b, pass_b, ffv_b}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle_vec", 32'(vec_a), 32'd0);
        chk("post_rst_idle_flags", {29'd0, busy_a, done_a, pass_a}, 32'd0);

        chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable self-checking response end for the switch-level gate library.
- Drives every input vector of a combinational gate under test (the NAND and its siblings), waits a settle window, samples the gate output and compares it against a parameterized truth table.
- Reports error count, first failing vector and pass/fail. Replaces hand-written stimulus benches with one reusable, clocked checker.

Parameters:
- N_IN, 2: number of gate inputs; vectors 0 .. 2^N_IN-1 are applied.
- TRUTH, 4'b0111: expected output table, width 2^N_IN. Bit i is the expected output for input vector i. The default is NAND.
- SETTLE, 2: clock cycles each vector is held before sampling. Legal range is 1 or more.
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a sweep.
- vec_out  output  N_IN  drives the gate inputs. Bit 0 is the LSB input, e.g. {a,b} = vec_out[1:0].
- dut_out  input  1  gate output under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high once the sweep completes; held until the next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- first_fail_valid  output  1  set at the first mismatch of a sweep.
- first_fail_vec  output  N_IN  vector index of the first mismatch.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values while rst_n=0, applied immediately regardless of clk:
  - state=IDLE
  - vec_out=0, busy=0, done=0, pass=0
  - err_count=0, first_fail_valid=0, first_fail_vec=0
  - internal settle counter=0
- Reset asserted mid-sweep aborts the sweep with no partial result retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - next cycle: state=SETTLE, vec_out=0, settle counter=0, busy=1, done=0, pass=0.
  - err_count, first_fail_valid and first_fail_vec clear to 0.
- SETTLE:
  - vec_out is held constant; the counter increments every cycle.
  - When counter==SETTLE-1, go to SAMPLE.
  - Each vector therefore spends exactly SETTLE cycles in SETTLE.
- SAMPLE (one cycle):
  - dut_out is compared with TRUTH[vec_out] using case equality, so X or Z on dut_out counts as a mismatch in simulation.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1. If first_fail_valid=0, latch first_fail_vec=vec_out and set first_fail_valid=1.
  - If vec_out is all ones: go to DONE.
  - Otherwise: vec_out increments by 1, counter=0, go to SETTLE.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - vec_out holds the last vector, all ones.
  - Outputs remain stable until start or reset.
- Latency: start accepted at edge T gives done=1 after edge T + 2^N_IN*(SETTLE+1). With defaults that is 12 cycles.
- start while busy=1 is ignored; the sweep continues unaffected.
- start on the same edge that enters DONE is ignored. It is honoured from the following cycle.
- vec_out changes only on the edge leaving SAMPLE (or on start). It is glitch-free, registered, and never changes inside a settle window.
- The sampled comparison uses the value of dut_out present at the SAMPLE edge. No combinational path exists from dut_out to any output.
- Width rules:
  - The vector counter is exactly N_IN bits; no wrap occurs because the sweep terminates at all ones.
  - The settle counter width is clog2(SETTLE)+1.

Test Plan:
1. Ideal behavioural NAND on vec_out[1:0], defaults, start pulse → busy=1 for 12 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0, vec_out=2'b11.
2. dut_out tied to 1 (stuck-at-1) → done after 12 cycles, err_count=1, first_fail_vec=2'b11, pass=0.
3. AND gate connected instead of NAND → err_count=4, first_fail_vec=2'b00, pass=0. Then a second start with NAND reconnected → err_count returns to 0, pass=1.
4. dut_out left floating (Z) → err_count=4, first_fail_vec=0, pass=0. Additionally, start re-pulsed at cycle 5 mid-sweep → ignored, done still at cycle 12.
5. rst_n driven low at cycle 7 of a sweep → all outputs 0 immediately. After release with no start, the block stays IDLE with vec_out=0.
6. N_IN=3, TRUTH=8'h00, SETTLE=1, ERR_W=2, dut_out=1 → done after 16 cycles, err_count saturates at 3, first_fail_vec=3'b000.
